// File: rtl/y86_pkg.sv
// Shared Y86 constants: icodes, status codes and the sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } state_t;

endpackage

// File: rtl/seq_mem_class.sv
// Combinational classifier: flags icodes that need a data-memory stage.
module seq_mem_class
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       needs_mem
);

    always_comb begin
        needs_mem = 1'b0;
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: needs_mem = 1'b1;
            default:                                      needs_mem = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Sequential Y86 stage controller: steps one instruction through the stages.
// Optional retired-instruction counter enabled by SEQ_CTRL_RETIRE_CNT_EN.
module seq_stage_controller
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        imem_error,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        dmem_error,
    output logic        d_en,
    output logic        e_en,
    output logic        w_en,
    output logic        pc_en,
    output logic [2:0]  stat,
`ifdef SEQ_CTRL_RETIRE_CNT_EN
    output logic        halted,
    output logic [63:0] retired_cnt
`else
    output logic        halted
`endif
);

    state_t     state, state_next;
    logic [2:0] stat_q, stat_next;
    logic       needs_mem;

    seq_mem_class u_mem_class (
        .icode     (icode),
        .needs_mem (needs_mem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            stat_q <= SAOK;
        end else begin
            state  <= state_next;
            stat_q <= stat_next;
        end
    end

    // Acks are only examined in the state that raised the matching request.
    always_comb begin
        state_next = state;
        stat_next  = stat_q;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (imem_error) begin
                        state_next = ST_HALT;
                        stat_next  = SADR;
                    end else if (!instr_valid) begin
                        state_next = ST_HALT;
                        stat_next  = SINS;
                    end else if (icode == IHALT) begin
                        state_next = ST_HALT;
                        stat_next  = SHLT;
                    end else begin
                        state_next = ST_DECODE;
                    end
                end
            end
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = needs_mem ? ST_MEMORY : ST_WRITEBACK;
            ST_MEMORY: begin
                if (dmem_ack) begin
                    if (dmem_error) begin
                        state_next = ST_HALT;
                        stat_next  = SADR;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: state_next = ST_PCUPD;
            ST_PCUPD:     state_next = ST_FETCH;
            ST_HALT:      state_next = ST_HALT;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign imem_req = (state == ST_FETCH);
    assign dmem_req = (state == ST_MEMORY);
    assign d_en     = (state == ST_DECODE);
    assign e_en     = (state == ST_EXECUTE);
    assign w_en     = (state == ST_WRITEBACK);
    assign pc_en    = (state == ST_PCUPD);
    assign halted   = (state == ST_HALT);
    assign stat     = stat_q;

`ifdef SEQ_CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= '0;
        else if (state == ST_PCUPD) retired_cnt <= retired_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed self-checking bench for seq_stage_controller.
module tb_seq_stage_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_req, imem_ack, imem_error;
    logic        dmem_req, dmem_ack, dmem_error;
    logic        d_en, e_en, w_en, pc_en;
    logic [2:0]  stat;
    logic        halted;
`ifdef SEQ_CTRL_RETIRE_CNT_EN
    logic [63:0] retired_cnt;
`endif

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Observed output vector: {imem_req, dmem_req, d_en, e_en, w_en, pc_en, halted}
    logic [6:0] obs;
    assign obs = {imem_req, dmem_req, d_en, e_en, w_en, pc_en, halted};

    localparam logic [6:0] V_Z = 7'b0000000;
    localparam logic [6:0] V_F = 7'b1000000;
    localparam logic [6:0] V_M = 7'b0100000;
    localparam logic [6:0] V_D = 7'b0010000;
    localparam logic [6:0] V_E = 7'b0001000;
    localparam logic [6:0] V_W = 7'b0000100;
    localparam logic [6:0] V_P = 7'b0000010;
    localparam logic [6:0] V_H = 7'b0000001;

    always #5 clk = ~clk;

    seq_stage_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_error  (imem_error),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .dmem_error  (dmem_error),
        .d_en        (d_en),
        .e_en        (e_en),
        .w_en        (w_en),
        .pc_en       (pc_en),
        .stat        (stat),
`ifdef SEQ_CTRL_RETIRE_CNT_EN
        .halted      (halted),
        .retired_cnt (retired_cnt)
`else
        .halted      (halted)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Wait for the next falling edge, then compare outputs and status.
    task automatic step(input string tag, input logic [6:0] exp_v, input logic [2:0] exp_stat);
        @(negedge clk);
        chk({tag, ".outs"}, 64'(obs), 64'(exp_v));
        chk({tag, ".stat"}, 64'(stat), 64'(exp_stat));
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst.outs", 64'(obs), 64'(V_Z));
        chk("rst.stat", 64'(stat), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_valid = 1'b1;
        imem_ack = 1'b1; imem_error = 1'b0; dmem_ack = 1'b1; dmem_error = 1'b0;

        // Reset state, with stray acks present
        step("reset", V_Z, 3'd1);
        rst_n = 1'b1;
        step("idle_ack_ignored", V_Z, 3'd1);

        // Three nops with same-cycle ack; stray dmem_ack must not matter
        start = 1'b1;
        step("nop.fetch0", V_F, 3'd1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("nop.decode", V_D, 3'd1);
            step("nop.execute", V_E, 3'd1);
            step("nop.writeback", V_W, 3'd1);
            step("nop.pcupd", V_P, 3'd1);
            step("nop.refetch", V_F, 3'd1);
        end
`ifdef SEQ_CTRL_RETIRE_CNT_EN
        chk("retired_cnt3", retired_cnt, 64'd3);
`endif
        imem_ack = 1'b0; dmem_ack = 1'b0;
        step("fetch_stall", V_F, 3'd1);

        // mrmovq with dmem_ack delayed 3 cycles
        icode = 4'h5; imem_ack = 1'b1;
        step("mr.decode", V_D, 3'd1);
        imem_ack = 1'b0;
        step("mr.execute", V_E, 3'd1);
        step("mr.mem1", V_M, 3'd1);
        step("mr.mem2", V_M, 3'd1);
        step("mr.mem3", V_M, 3'd1);
        step("mr.mem4", V_M, 3'd1);
        dmem_ack = 1'b1;
        step("mr.writeback", V_W, 3'd1);
        dmem_ack = 1'b0;
        step("mr.pcupd", V_P, 3'd1);
        step("mr.refetch", V_F, 3'd1);

        // halt instruction: sticky HALT, start ignored
        icode = 4'h0; imem_ack = 1'b1;
        step("hlt.halt", V_H, 3'd2);
        imem_ack = 1'b0; start = 1'b1;
        step("hlt.sticky1", V_H, 3'd2);
        step("hlt.sticky2", V_H, 3'd2);
        start = 1'b0;

        // ADR takes priority over INS
        reset_now();
        start = 1'b1; icode = 4'h1;
        step("adr.fetch", V_F, 3'd1);
        start = 1'b0; imem_error = 1'b1; instr_valid = 1'b0; imem_ack = 1'b1;
        step("adr.halt", V_H, 3'd3);

        // Illegal instruction alone
        reset_now();
        imem_ack = 1'b0; start = 1'b1;
        step("ins.fetch", V_F, 3'd1);
        start = 1'b0; imem_error = 1'b0; instr_valid = 1'b0; imem_ack = 1'b1;
        step("ins.halt", V_H, 3'd4);
        instr_valid = 1'b1; imem_ack = 1'b0;

        // Reset in the middle of a data-memory handshake
        reset_now();
        icode = 4'h5; start = 1'b1;
        step("rmem.fetch", V_F, 3'd1);
        start = 1'b0; imem_ack = 1'b1;
        step("rmem.decode", V_D, 3'd1);
        imem_ack = 1'b0;
        step("rmem.execute", V_E, 3'd1);
        step("rmem.mem", V_M, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("rmem.rst.outs", 64'(obs), 64'(V_Z));
        chk("rmem.rst.stat", 64'(stat), 64'd1);
`ifdef SEQ_CTRL_RETIRE_CNT_EN
        chk("rmem.rst.cnt", retired_cnt, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("rmem.idle", V_Z, 3'd1);

        // Data address fault on rmmovq
        icode = 4'h4; start = 1'b1; imem_ack = 1'b1;
        step("dadr.fetch", V_F, 3'd1);
        start = 1'b0;
        step("dadr.decode", V_D, 3'd1);
        imem_ack = 1'b0;
        step("dadr.execute", V_E, 3'd1);
        dmem_ack = 1'b1; dmem_error = 1'b1;
        step("dadr.mem", V_M, 3'd1);
        step("dadr.halt", V_H, 3'd3);
        dmem_ack = 1'b0; dmem_error = 1'b0;
        step("dadr.sticky", V_H, 3'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  begin execution from IDLE.
REQ-004 SHALL have port: icode  input  4  opcode from fetch datapath, valid when imem_ack=1.
REQ-005 SHALL have port: instr_valid  input  1  fetch decoded a legal icode/ifun.
REQ-006 SHALL have port: imem_req / imem_ack  output / input  1 / 1  instruction-memory handshake.
REQ-007 SHALL have port: imem_error  input  1  fetch address fault, valid with imem_ack.
REQ-008 SHALL have port: dmem_req / dmem_ack  output / input  1 / 1  data-memory handshake.
REQ-009 SHALL have port: dmem_error  input  1  data address fault, valid with dmem_ack.
REQ-010 SHALL have port: d_en, e_en, w_en, pc_en  output  1 each  stage enables for decode, execute, writeback, PC update.
REQ-011 SHALL have port: stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-012 SHALL have port: halted  output  1  machine stopped.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-014 SHALL move IDLE->FETCH when start=1; start SHALL be ignored in all other states.
REQ-015 SHALL hold imem_req=1 throughout FETCH and stay in FETCH until imem_ack=1.
REQ-016 On FETCH with imem_ack=1: imem_error=1 -> HALT with stat=ADR; else instr_valid=0 -> HALT with stat=INS; else icode=0 -> HALT with stat=HLT; else -> DECODE (priority in that order).
REQ-017 SHALL sequence DECODE->EXECUTE, one cycle each.
REQ-018 SHALL go EXECUTE->MEMORY for icode 4,5,8,9,A,B, else EXECUTE->WRITEBACK.
REQ-019 SHALL hold dmem_req=1 throughout MEMORY until dmem_ack=1; dmem_error=1 with ack -> HALT, stat=ADR; else -> WRITEBACK.
REQ-020 SHALL sequence WRITEBACK->PCUPD->FETCH, one cycle each.
REQ-021 Enables SHALL be Moore decodes of state: d_en in DECODE, e_en in EXECUTE, w_en in WRITEBACK, pc_en in PCUPD only; at most one asserted per cycle.
REQ-022 Min latency FETCH-entry to next FETCH-entry with same-cycle ack: 5 cycles non-memory, 6 cycles memory icode.
REQ-023 Acks arriving while the matching req is low SHALL be ignored.
REQ-024 HALT SHALL be sticky until rst_n low; halted=1, no req or enable asserted; stat holds fault code.
REQ-025 pc_en SHALL never assert for a faulting or halt instruction.

Reset
REQ-026 rst_n low SHALL force, immediately and regardless of state, IDLE, stat=AOK, halted=0, all reqs and enables 0.
REQ-027 Reset mid-handshake SHALL drop the pending req with no further action; the next operation requires start.

Configuration
REQ-028 With SEQ_CTRL_RETIRE_CNT_EN defined: output retired_cnt (64-bit), reset 0, increments by 1 in each PCUPD cycle, wraps at 2^64.
REQ-029 Without SEQ_CTRL_RETIRE_CNT_EN: retired_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package y86_pkg SHALL hold icode constants (IHALT..IPOPQ), stat codes (SAOK, SHLT, SADR, SINS) and the FSM state enum.
REQ-031 A sub-module seq_mem_class (combinational: icode -> needs-memory flag) is natural; all other logic flat.

Verification
REQ-032 Reset, start=1, icode=1 (nop), imem_ack same cycle -> d_en,e_en,w_en,pc_en each pulse once in order; FETCH re-entered 5 cycles later.
REQ-033 icode=5 (mrmovq), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, pc_en once, WRITEBACK never before ack.
REQ-034 icode=0 at fetch ack -> HALT, stat=2, halted=1, pc_en never asserted; later start=1 ignored.
REQ-035 imem_error=1 and instr_valid=0 together -> stat=3 (ADR priority), halted=1.
REQ-036 rst_n low during MEMORY with dmem_req=1 -> dmem_req=0 same cycle, state IDLE, stat=1; retired_cnt=0 when macro defined.
REQ-037 Macro defined, 3 nops retired -> retired_cnt=3.
